// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller FSM encoding and scan-code prefix bytes.
package ps2_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_DECODE = 2'd2
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_key_ctrl.sv
// Pops scan-code bytes from the PS/2 keyboard FIFO and tracks the most recent
// make event, the held key, a press counter and a sticky FIFO overflow flag.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter bit IGNORE_REPEAT = 1'b1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       kb_nextdata_n,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_down,
   output logic       key_valid,
   output logic [7:0] press_cnt,
   output logic       ovf_flag
);

   ps2_state_t state, state_nxt;
   logic [7:0] byte_q;
   logic       ext_pend;
   logic       brk_pend;
   logic       key_match;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (kb_ready) state_nxt = S_POP;
         S_POP:    state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Strobe decoded from state so reset deasserts it immediately.
   assign kb_nextdata_n = (state != S_POP);

   assign key_match = key_down && ({ext_pend, byte_q} == {key_ext, key_code});

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         byte_q    <= 8'h00;
         ext_pend  <= 1'b0;
         brk_pend  <= 1'b0;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         key_down  <= 1'b0;
         key_valid <= 1'b0;
         press_cnt <= 8'h00;
         ovf_flag  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (kb_overflow) ovf_flag <= 1'b1;
         if (state == S_IDLE && kb_ready) byte_q <= kb_data;
         if (state == S_DECODE) begin
            if (byte_q == PS2_EXT) begin
               ext_pend <= 1'b1;
            end else if (byte_q == PS2_BRK) begin
               brk_pend <= 1'b1;
            end else begin
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
               if (brk_pend) begin
                  // Releasing some other key leaves the held key untouched.
                  if (key_match) key_down <= 1'b0;
               end else if (!(key_match && IGNORE_REPEAT)) begin
                  key_code  <= byte_q;
                  key_ext   <= ext_pend;
                  key_down  <= 1'b1;
                  key_valid <= 1'b1;
                  press_cnt <= press_cnt + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench: two controllers (repeats ignored / counted) share one modelled keyboard
// FIFO; a scan-code level model predicts every output on every falling edge.
module tb_ps2_key_ctrl;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic [7:0] kb_data = 8'h00;

   logic       nd   [2];
   logic [7:0] code [2];
   logic       ext  [2];
   logic       down [2];
   logic       vld  [2];
   logic [7:0] cnt  [2];
   logic       ovf  [2];

   ps2_key_ctrl #(.IGNORE_REPEAT(1'b1)) u_ign (
      .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nd[0]), .key_code(code[0]),
      .key_ext(ext[0]), .key_down(down[0]), .key_valid(vld[0]),
      .press_cnt(cnt[0]), .ovf_flag(ovf[0]));

   ps2_key_ctrl #(.IGNORE_REPEAT(1'b0)) u_rep (
      .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(nd[1]), .key_code(code[1]),
      .key_ext(ext[1]), .key_down(down[1]), .key_valid(vld[1]),
      .press_cnt(cnt[1]), .ovf_flag(ovf[1]));

   always #5 clk = ~clk;

   // Keyboard FIFO contents are src[rd_ptr .. src_n-1].
   logic [7:0] src [0:2047];
   int         src_n = 0;
   int         rd_ptr = 0;

   // Model state, one slot per instance.
   logic [7:0] m_code [2];
   logic       m_ext  [2];
   logic       m_down [2];
   logic       m_vld  [2];
   logic [7:0] m_cnt  [2];
   logic       m_pe   [2];
   logic       m_pb   [2];
   logic       m_ovf = 1'b0;
   logic       ovf_seen = 1'b0;
   logic [7:0] pend_byte = 8'h00;
   int         cd = 0;
   int         strobes = 0;
   int         pulses [2];
   logic       prev_low = 1'b0;

   int mon_checks = 0, mon_passed = 0;
   int lit_checks = 0, lit_passed = 0;

   function automatic void mchk(string name, int i, int act, int exp);
      mon_checks++;
      if (act == exp) mon_passed++;
      else $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, i, $time, act, exp);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_code[i] = 8'h00; m_ext[i] = 1'b0; m_down[i] = 1'b0; m_vld[i] = 1'b0;
         m_cnt[i] = 8'h00;  m_pe[i] = 1'b0;  m_pb[i] = 1'b0;
      end
      m_ovf = 1'b0;
   endfunction

   // Scan-code rules: prefixes arm, anything else is a make or a break.
   function automatic void model_byte(int i, logic [7:0] b);
      logic same;
      same = m_down[i] && (m_code[i] == b) && (m_ext[i] == m_pe[i]);
      if (b == 8'hE0) m_pe[i] = 1'b1;
      else if (b == 8'hF0) m_pb[i] = 1'b1;
      else begin
         if (m_pb[i]) begin
            if (same) m_down[i] = 1'b0;
         end else if (!(same && i == 0)) begin
            m_code[i] = b; m_ext[i] = m_pe[i]; m_down[i] = 1'b1;
            m_vld[i] = 1'b1; m_cnt[i] = m_cnt[i] + 8'd1;
         end
         m_pe[i] = 1'b0; m_pb[i] = 1'b0;
      end
   endfunction

   initial begin
      model_reset();
      pulses[0] = 0; pulses[1] = 0;
   end

   always @(negedge clk) begin
      if (!clrn) begin
         model_reset();
         cd = 0;
      end else begin
         if (ovf_seen) m_ovf = 1'b1;
         for (int i = 0; i < 2; i++) m_vld[i] = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) for (int i = 0; i < 2; i++) model_byte(i, pend_byte);
         end
      end
      for (int i = 0; i < 2; i++) begin
         mchk("key_code", i, code[i], m_code[i]);
         mchk("key_ext", i, ext[i], m_ext[i]);
         mchk("key_down", i, down[i], m_down[i]);
         mchk("key_valid", i, vld[i], m_vld[i]);
         mchk("press_cnt", i, cnt[i], m_cnt[i]);
         mchk("ovf_flag", i, ovf[i], m_ovf);
         if (vld[i]) pulses[i]++;
      end
      mchk("strobe_lockstep", 1, nd[1], nd[0]);
      if (!nd[0]) mchk("strobe_single_cycle", 0, prev_low, 0);
      if (!clrn) mchk("strobe_in_reset", 0, nd[0], 1);
      prev_low = !nd[0];
      if (!nd[0]) begin
         strobes++;
         if (rd_ptr < src_n) begin
            pend_byte = src[rd_ptr];
            rd_ptr++;
            cd = 2;
         end
      end
      ovf_seen = clrn && kb_overflow;
      kb_ready = (rd_ptr < src_n);
      kb_data  = (rd_ptr < src_n) ? src[rd_ptr] : 8'h00;
   end

   task automatic lchk(string name, int act, int exp);
      lit_checks++;
      if (act == exp) lit_passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(logic [7:0] b);
      src[src_n] = b;
      src_n++;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while ((rd_ptr < src_n || cd != 0) && n < budget) begin
         @(posedge clk); n++;
      end
      if (n >= budget) lchk("drain_timeout", n, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 clrn = 1'b0;
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
   endtask

   int s0, p0, p1;
   logic [7:0] c0, c1;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      lchk("reset_code", code[0], 8'h00);
      lchk("reset_strobe", nd[0], 1);
      clrn = 1'b1;

      s0 = strobes; p0 = pulses[0];
      push(8'h1C); drain(100);
      lchk("make_strobes", strobes - s0, 1);
      lchk("make_pulses", pulses[0] - p0, 1);
      lchk("make_code", code[0], 8'h1C);
      lchk("make_ext", ext[0], 0);
      lchk("make_down", down[0], 1);
      lchk("make_cnt", cnt[0], 1);

      s0 = strobes; p0 = pulses[0];
      push(8'hF0); push(8'h1C); drain(100);
      lchk("break_strobes", strobes - s0, 2);
      lchk("break_pulses", pulses[0] - p0, 0);
      lchk("break_down", down[0], 0);
      lchk("break_cnt", cnt[0], 1);

      p0 = pulses[0];
      push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75); drain(200);
      lchk("ext_pulses", pulses[0] - p0, 1);
      lchk("ext_code", code[0], 8'h75);
      lchk("ext_ext", ext[0], 1);
      lchk("ext_down", down[0], 0);
      push(8'h1C); drain(100);
      lchk("after_ext_ext", ext[0], 0);
      lchk("after_ext_code", code[0], 8'h1C);
      push(8'hF0); push(8'h1C); drain(100);

      c0 = cnt[0]; c1 = cnt[1]; p0 = pulses[0]; p1 = pulses[1];
      push(8'h1C); push(8'h1C); push(8'h1C); drain(200);
      lchk("repeat_cnt_ign", 8'(cnt[0] - c0), 1);
      lchk("repeat_cnt_rep", 8'(cnt[1] - c1), 3);
      lchk("repeat_pulses_ign", pulses[0] - p0, 1);
      lchk("repeat_pulses_rep", pulses[1] - p1, 3);

      push(8'hF0); push(8'h2B); drain(100);
      lchk("other_release_down", down[0], 1);
      push(8'hF0); push(8'h1C);
      push(8'hE1); push(8'hF0); push(8'hE1); drain(200);
      lchk("e1_code", code[0], 8'hE1);
      lchk("e1_down", down[0], 0);

      do_reset();
      for (int k = 0; k < 256; k++) begin
         push(8'h1C); push(8'hF0); push(8'h1C);
      end
      drain(4000);
      lchk("wrap_cnt_ign", cnt[0], 8'h00);
      lchk("wrap_cnt_rep", cnt[1], 8'h00);

      @(posedge clk); #2 kb_overflow = 1'b1;
      @(posedge clk); #2 kb_overflow = 1'b0;
      push(8'h3A); drain(100);
      lchk("ovf_set", ovf[0], 1);
      lchk("ovf_decode_cnt", cnt[0], 8'h01);

      push(8'hF0); drain(100);
      push(8'h1C);
      begin
         int n = 0;
         do begin
            @(posedge clk); #1; n++;
         end while (nd[0] && n < 50);
         lchk("pop_seen", nd[0], 0);
      end
      clrn = 1'b0;
      #1;
      lchk("rst_strobe", nd[0], 1);
      lchk("rst_cnt", cnt[0], 8'h00);
      lchk("rst_ovf", ovf[0], 0);
      lchk("rst_code", code[0], 8'h00);
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
      drain(100);
      lchk("post_rst_code", code[0], 8'h1C);
      lchk("post_rst_down", down[0], 1);
      lchk("post_rst_cnt", cnt[0], 8'h01);

      $display("%0d/%0d checks passed", mon_passed + lit_passed, mon_checks + lit_checks);
      $finish;
   end

endmodule
